// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access to a single-cycle-or-stalling data RAM,
// with alignment/width checking, byte-lane steering, load extension and an access timeout.
module load_store_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  tcnt_p0;
    logic        store_p0;
    logic [2:0]  funct3_p0;
    logic [1:0]  lane_p0;
    logic [29:0] waddr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  we_p0;
    logic [4:0]  rd_p0;

    logic        accept;
    logic        illegal;
    logic        timeout;

    function automatic logic is_illegal(input logic store, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic bad;
        case (f3)
            3'd0:    bad = 1'b0;
            3'd1:    bad = lane[0];
            3'd2:    bad = |lane;
            3'd4:    bad = store;
            3'd5:    bad = store | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic store, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [3:0] be;
        if (!store) begin
            be = 4'b0000;
        end else begin
            case (f3)
                3'd0:    be = 4'b0001 << lane;
                3'd1:    be = 4'b0011 << lane;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicate store data across lanes so the RAM only needs the byte enables.
    function automatic logic [31:0] replicate_lanes(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] r;
        case (f3)
            3'd0:    r = {4{data[7:0]}};
            3'd1:    r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign illegal   = is_illegal(req_store, req_funct3, req_addr[1:0]);
    assign timeout   = (tcnt_p0 == TMO_LAST);

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en ? we_p0    : 4'b0000;
    assign mem_addr  = mem_en ? waddr_p0 : 30'd0;
    assign mem_wdata = mem_en ? wdata_p0 : 32'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = illegal ? DONE : ACCESS;
            ACCESS:  if (mem_ready || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: request latch and access tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tcnt_p0   <= 8'd0;
            store_p0  <= 1'b0;
            funct3_p0 <= 3'd0;
            lane_p0   <= 2'd0;
            waddr_p0  <= 30'd0;
            wdata_p0  <= 32'd0;
            we_p0     <= 4'b0000;
            rd_p0     <= 5'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tcnt_p0   <= 8'd0;
                store_p0  <= req_store;
                funct3_p0 <= req_funct3;
                lane_p0   <= req_addr[1:0];
                waddr_p0  <= req_addr[31:2];
                wdata_p0  <= replicate_lanes(req_funct3, req_wdata);
                we_p0     <= byte_enables(req_store, req_funct3, req_addr[1:0]);
                rd_p0     <= req_rd;
            end else if (state == ACCESS) begin
                tcnt_p0 <= tcnt_p0 + 8'd1;
            end
        end
    end

    // p1: registered response, zero outside the single DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rd    <= 5'd0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rd    <= 5'd0;
            resp_rdata <= 32'd0;
            if (accept && illegal) begin
                resp_valid <= 1'b1;
                resp_fault <= 1'b1;
            end else if (state == ACCESS && mem_ready) begin
                resp_valid <= 1'b1;
                if (!store_p0) begin
                    resp_rd    <= rd_p0;
                    resp_rdata <= extend_load(funct3_p0, lane_p0, mem_rdata);
                end
            end else if (state == ACCESS && timeout) begin
                resp_valid <= 1'b1;
                resp_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops against a
// behavioural model of alignment, lane steering, extension, latency and timeout.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_fault(resp_fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Reference model
    function automatic bit m_illegal(input bit st, input int f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (st) return !(f3 == 0 || (f3 == 1 && off % 2 == 0) || (f3 == 2 && off == 0));
        if (f3 == 0 || f3 == 4) return 0;
        if (f3 == 1 || f3 == 5) return (off % 2) != 0;
        if (f3 == 2) return off != 0;
        return 1;
    endfunction

    function automatic logic [3:0] m_we(input int f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (f3 == 0) return 4'(1 << off);
        if (f3 == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
        if (f3 == 0) return (d % 256) * 32'h01010101;
        if (f3 == 1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] w);
        longint v;
        int off;
        off = int'(a % 4);
        if (f3 == 0 || f3 == 4) begin
            v = longint'((w >> (8 * off)) % 256);
            if (f3 == 0 && v >= 128) v = v - 256;
        end else if (f3 == 1 || f3 == 5) begin
            v = longint'((w >> (16 * (off / 2))) % 65536);
            if (f3 == 1 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return 32'(v);
    endfunction

    // Drives one request and gathers what the DUT did; callers decide what is correct.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int wt,
                          input logic [31:0] rdw,
                          output int lat, output int n_en, output logic [29:0] o_addr,
                          output logic [3:0] o_we, output logic [31:0] o_wd, output bit stable,
                          output logic o_fault, output logic [4:0] o_rd, output logic [31:0] o_rdata,
                          output logic post_valid, output logic pre_ready);
        lat = -1; n_en = 0; stable = 1; o_addr = '0; o_we = '0; o_wd = '0;
        o_fault = 0; o_rd = '0; o_rdata = '0; post_valid = 0;
        @(negedge clk);
        req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        mem_ready = 0;
        pre_ready = req_ready;
        @(negedge clk);
        req_valid = 0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        for (int c = 1; c <= 40; c++) begin
            mem_ready = 0; mem_rdata = $urandom;
            if (resp_valid) begin
                lat = c; o_fault = resp_fault; o_rd = resp_rd; o_rdata = resp_rdata;
                break;
            end
            if (mem_en) begin
                n_en++;
                if (n_en == 1) begin
                    o_addr = mem_addr; o_we = mem_we; o_wd = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wdata} !== {o_addr, o_we, o_wd}) begin
                    stable = 0;
                end
                if (n_en == wt + 1) begin
                    mem_ready = 1; mem_rdata = rdw;
                end
            end
            @(negedge clk);
        end
        mem_ready = 0;
        if (lat >= 0) begin
            @(negedge clk);
            post_valid = resp_valid;
        end
    endtask

    task automatic test_reset();
        reset = 1; req_valid = 1; req_store = 0; req_funct3 = 2; req_addr = 0;
        req_wdata = 0; req_rd = 1; mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_fault, resp_rd, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b rv=%b flt=%b rd=%0d rdata=%h en=%b we=%b addr=%h wd=%h, want all 0",
                     req_ready, resp_valid, resp_fault, resp_rd, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata);
        end
        req_valid = 0; mem_ready = 0; reset = 0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_store_directed();
        int lat, n_en; logic [29:0] ma; logic [3:0] we; logic [31:0] wd, rdata;
        bit stb; logic flt, pv, pr; logic [4:0] rd;
        run_op(1, 3'd2, 32'h80001004, 32'hDEADBEEF, 5'd9, 0, 32'h0, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
        n_cmp++;
        if ({lat, n_en} !== {32'd2, 32'd1}) begin
            n_err++; $display("FAIL sw_timing: got lat=%0d en_cycles=%0d want lat=2 en_cycles=1", lat, n_en);
        end
        n_cmp++;
        if ({ma, we, wd} !== {30'h20000401, 4'b1111, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL sw_mem: got addr=%h we=%b wd=%h want 20000401 1111 deadbeef", ma, we, wd);
        end
        n_cmp++;
        if ({flt, rd, rdata} !== {1'b0, 5'd0, 32'd0}) begin
            n_err++; $display("FAIL sw_resp: got flt=%b rd=%0d rdata=%h want 0 0 0", flt, rd, rdata);
        end
        run_op(1, 3'd0, 32'h80000003, 32'h000000A5, 5'd1, 0, 32'h0, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
        n_cmp++;
        if ({we, wd} !== {4'b1000, 32'hA5A5A5A5}) begin
            n_err++; $display("FAIL sb_mem: got we=%b wd=%h want 1000 a5a5a5a5", we, wd);
        end
        run_op(1, 3'd1, 32'h80000002, 32'h00001234, 5'd1, 1, 32'h0, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
        n_cmp++;
        if ({we, wd, lat} !== {4'b1100, 32'h12341234, 32'd3}) begin
            n_err++; $display("FAIL sh_mem: got we=%b wd=%h lat=%0d want 1100 12341234 3", we, wd, lat);
        end
    endtask

    task automatic test_load_directed();
        int lat, n_en; logic [29:0] ma; logic [3:0] we; logic [31:0] wd, rdata;
        bit stb; logic flt, pv, pr; logic [4:0] rd;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
        logic [31:0] ads [4] = '{32'h80000002, 32'h80000002, 32'h80000002, 32'h80000000};
        logic [31:0] exp [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'h12F03456};
        for (int i = 0; i < 4; i++) begin
            run_op(0, f3s[i], ads[i], 32'h0, 5'd5, 0, 32'h12F03456, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
            n_cmp++;
            if ({rdata, rd, flt, we, lat} !== {exp[i], 5'd5, 1'b0, 4'b0000, 32'd2}) begin
                n_err++;
                $display("FAIL load_f3_%0d: got rdata=%h rd=%0d flt=%b we=%b lat=%0d want %h 5 0 0000 2",
                         f3s[i], rdata, rd, flt, we, lat, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int lat, n_en; logic [29:0] ma; logic [3:0] we; logic [31:0] wd, rdata;
        bit stb; logic flt, pv, pr; logic [4:0] rd;
        logic [2:0]  f3s [3] = '{3'd2, 3'd3, 3'd5};
        logic [31:0] ads [3] = '{32'h80000002, 32'h80000000, 32'h80000000};
        bit          sts [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(sts[i], f3s[i], ads[i], 32'h55, 5'd5, 0, 32'h12345678, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
            n_cmp++;
            if ({lat, n_en} !== {32'd1, 32'd0}) begin
                n_err++; $display("FAIL illegal_%0d_timing: got lat=%0d en_cycles=%0d want 1 0", i, lat, n_en);
            end
            n_cmp++;
            if ({flt, rd, rdata, pv} !== {1'b1, 5'd0, 32'd0, 1'b0}) begin
                n_err++; $display("FAIL illegal_%0d_resp: got flt=%b rd=%0d rdata=%h next_valid=%b want 1 0 0 0",
                                  i, flt, rd, rdata, pv);
            end
        end
    endtask

    task automatic test_timeout();
        int lat = -1, n_en = 0, busy_rdy = 0;
        logic flt = 0; logic [4:0] rd = '0; logic [31:0] rdata = '0;
        @(negedge clk);
        req_valid = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h80000010; req_rd = 5'd3;
        mem_ready = 0;
        @(negedge clk);
        req_funct3 = 3'd0; req_addr = 32'h80000011; req_rd = 5'd7;
        for (int c = 1; c <= 30; c++) begin
            if (resp_valid) begin
                lat = c; flt = resp_fault; rd = resp_rd; rdata = resp_rdata; req_valid = 0;
                break;
            end
            if (mem_en) n_en++;
            if (req_ready) busy_rdy++;
            @(negedge clk);
        end
        req_valid = 0;
        n_cmp++;
        if ({n_en, lat} !== {TMO, TMO + 1}) begin
            n_err++; $display("FAIL timeout_timing: got en_cycles=%0d lat=%0d want %0d %0d", n_en, lat, TMO, TMO + 1);
        end
        n_cmp++;
        if ({flt, rd, rdata} !== {1'b1, 5'd0, 32'd0}) begin
            n_err++; $display("FAIL timeout_resp: got flt=%b rd=%0d rdata=%h want 1 0 0", flt, rd, rdata);
        end
        n_cmp++;
        if (busy_rdy !== 0) begin
            n_err++; $display("FAIL timeout_busy_ready: got %0d ready cycles while busy want 0", busy_rdy);
        end
        @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, mem_en} !== 3'b100) begin
            n_err++; $display("FAIL timeout_after: got ready=%b rv=%b en=%b want 1 0 0", req_ready, resp_valid, mem_en);
        end
    endtask

    task automatic test_reset_mid();
        int lat, n_en, stray = 0; logic [29:0] ma; logic [3:0] we; logic [31:0] wd, rdata;
        bit stb; logic flt, pv, pr; logic [4:0] rd;
        @(negedge clk);
        req_valid = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h80000020; req_rd = 5'd4;
        mem_ready = 0;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b1) begin
            n_err++; $display("FAIL rstmid_stall: got mem_en=%b want 1", mem_en);
        end
        reset = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, resp_valid} !== 2'b00) begin
            n_err++; $display("FAIL rstmid_abandon: got en=%b rv=%b want 0 0", mem_en, resp_valid);
        end
        reset = 0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_ready: got %b want 1", req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1;
            if (resp_valid || mem_en) stray++;
            @(negedge clk);
        end
        mem_ready = 0;
        n_cmp++;
        if (stray !== 0) begin
            n_err++; $display("FAIL rstmid_stray: got %0d active cycles want 0", stray);
        end
        run_op(0, 3'd2, 32'h80000024, 32'h0, 5'd12, 1, 32'hCAFEF00D, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
        n_cmp++;
        if ({rdata, rd, flt, lat, ma} !== {32'hCAFEF00D, 5'd12, 1'b0, 32'd3, 30'h20000009}) begin
            n_err++; $display("FAIL rstmid_next_lw: got rdata=%h rd=%0d flt=%b lat=%0d addr=%h want cafef00d 12 0 3 20000009",
                              rdata, rd, flt, lat, ma);
        end
    endtask

    task automatic test_random();
        int lat, n_en; logic [29:0] ma; logic [3:0] we; logic [31:0] wd, rdata;
        bit stb; logic flt, pv, pr; logic [4:0] rd;
        for (int i = 0; i < 60; i++) begin
            bit st; int f3, wt; logic [31:0] a, d, w; logic [4:0] r; bit ill;
            logic [31:0] e_rdata; logic [4:0] e_rd;
            st = 1'($urandom); f3 = $urandom_range(0, 7); wt = $urandom_range(0, TMO - 1);
            a = 32'h80000000 | ($urandom % 4096); d = $urandom; w = $urandom; r = 5'($urandom);
            ill = m_illegal(st, f3, a);
            run_op(st, 3'(f3), a, d, r, wt, w, lat, n_en, ma, we, wd, stb, flt, rd, rdata, pv, pr);
            n_cmp++;
            if ({lat, n_en, pr, pv} !== {(ill ? 32'd1 : 32'(2 + wt)), (ill ? 32'd0 : 32'(wt + 1)), 1'b1, 1'b0}) begin
                n_err++; $display("FAIL rand_%0d_timing: st=%0d f3=%0d a=%h wt=%0d got lat=%0d en=%0d ready=%b next_valid=%b",
                                  i, st, f3, a, wt, lat, n_en, pr, pv);
            end
            if (!ill) begin
                n_cmp++;
                if ({ma, we, stb} !== {a[31:2], (st ? m_we(f3, a) : 4'b0000), 1'b1}) begin
                    n_err++; $display("FAIL rand_%0d_mem: got addr=%h we=%b stable=%0d want %h %b 1",
                                      i, ma, we, stb, a[31:2], st ? m_we(f3, a) : 4'b0000);
                end
                if (st) begin
                    n_cmp++;
                    if (wd !== m_wdata(f3, d)) begin
                        n_err++; $display("FAIL rand_%0d_wdata: got %h want %h", i, wd, m_wdata(f3, d));
                    end
                end
            end
            e_rd    = (ill || st) ? 5'd0 : r;
            e_rdata = (ill || st) ? 32'd0 : m_load(f3, a, w);
            n_cmp++;
            if ({flt, rd, rdata} !== {1'(ill), e_rd, e_rdata}) begin
                n_err++; $display("FAIL rand_%0d_resp: st=%0d f3=%0d a=%h got flt=%b rd=%0d rdata=%h want %b %0d %h",
                                  i, st, f3, a, flt, rd, rdata, ill, e_rd, e_rdata);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_directed();
        test_load_directed();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
